// File: rtl/servo_motion_ctrl.sv
// servo_motion_ctrl
//   Multi-channel motion controller feeding per-joint servo_pwm instances.
//   Accepts per-channel target widths over a valid/ready command port and
//   slews each channel's width toward its target by at most STEP_US once per
//   PWM frame, so every servo frame sees a stable, smoothly changing width.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   cmd_valid/ready command handshake (cmd_ready is combinational)
//   cmd_ch          target channel; indices >= NUM_CH are accepted and dropped
//   cmd_width_us    requested width in us, clamped to [MIN, MAX]
//   halt            freeze every channel at its current width
//   width_us        packed current widths, channel i at [16*i +: 16]
//   busy            per-channel "still moving" flags
//   frame_tick      one-cycle pulse on the frame update cycle
//   all_idle        no channel busy

// Per-channel slew state: current width, target and busy flag.
module servo_ch #(
    parameter int HOME_US = 1_500,
    parameter int STEP_US = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    input  logic        tick,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] cur,
    output logic        busy,
    output logic        busy_d
);
    localparam logic [15:0] HOME = 16'(HOME_US);
    localparam logic [15:0] STEP = 16'(STEP_US);

    logic [15:0] tgt, tgt_d, cur_d, gap;

    // Stepping works on the unsigned gap to the target, so cur +/- STEP is
    // only formed when it lands strictly short of tgt: no overflow, no
    // overshoot.
    always_comb begin
        tgt_d = tgt;
        cur_d = cur;
        gap   = '0;
        if (halt) begin
            tgt_d = cur;
        end else if (tick) begin
            if (cur < tgt) begin
                gap   = tgt - cur;
                cur_d = (gap > STEP) ? cur + STEP : tgt;
            end else if (cur > tgt) begin
                gap   = cur - tgt;
                cur_d = (gap > STEP) ? cur - STEP : tgt;
            end
        end else if (load) begin
            tgt_d = load_val;
        end
        busy_d = (cur_d != tgt_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur  <= HOME;
            tgt  <= HOME;
            busy <= 1'b0;
        end else begin
            cur  <= cur_d;
            tgt  <= tgt_d;
            busy <= busy_d;
        end
    end
endmodule

module servo_motion_ctrl #(
    parameter int CLK_HZ             = 50_000_000,
    parameter int NUM_CH             = 4,
    parameter int FRAME_US           = 20_000,
    parameter int MIN_PULSE_WIDTH_US = 1_000,
    parameter int MAX_PULSE_WIDTH_US = 2_000,
    parameter int HOME_US            = 1_500,
    parameter int STEP_US            = 10,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [CH_W-1:0]      cmd_ch,
    input  logic [15:0]          cmd_width_us,
    input  logic                 halt,
    output logic [16*NUM_CH-1:0] width_us,
    output logic [NUM_CH-1:0]    busy,
    output logic                 frame_tick,
    output logic                 all_idle
);
    localparam int FRAME_TICKS = FRAME_US * (CLK_HZ / 1_000_000);
    localparam int CNT_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_TICKS - 1);
    localparam logic [15:0] WMIN = 16'(MIN_PULSE_WIDTH_US);
    localparam logic [15:0] WMAX = 16'(MAX_PULSE_WIDTH_US);

    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [15:0]       cmd_clamped;
    logic [NUM_CH-1:0] busy_d;
    logic              accept;

    always_comb cnt_nxt = (cnt == LAST) ? '0 : cnt + CNT_W'(1);

    // Blocking commands on the update cycle keeps a channel's target fixed
    // while it steps, so load and tick never meet inside a channel.
    assign cmd_ready = !rst && !halt && (cnt != LAST);
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        cmd_clamped = cmd_width_us;
        if (cmd_width_us < WMIN)      cmd_clamped = WMIN;
        else if (cmd_width_us > WMAX) cmd_clamped = WMAX;
    end

    // frame_tick is registered one cycle ahead so it is high exactly while
    // the counter sits on its last value; it then doubles as the update strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            frame_tick <= 1'b0;
            all_idle   <= 1'b1;
        end else begin
            cnt        <= cnt_nxt;
            frame_tick <= (cnt_nxt == LAST);
            all_idle   <= ~|busy_d;
        end
    end

    // Out-of-range channel indices match no instance, so they drop silently.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        servo_ch #(
            .HOME_US (HOME_US),
            .STEP_US (STEP_US)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .halt     (halt),
            .tick     (frame_tick),
            .load     (accept && (cmd_ch == CH_W'(i))),
            .load_val (cmd_clamped),
            .cur      (width_us[16*i +: 16]),
            .busy     (busy[i]),
            .busy_d   (busy_d[i])
        );
    end
endmodule

// File: tb/tb_servo_motion_ctrl.sv
// Scoreboard bench for servo_motion_ctrl (100-cycle frames, 4 channels).
// A frame-level reference model pushes the expected post-edge state every
// clock; an independent monitor pops and compares at each falling edge.
module tb_servo_motion_ctrl;
    localparam int NCH   = 4;
    localparam int FT    = 100;
    localparam int HOME  = 1500;
    localparam int STEP  = 10;
    localparam int WLO   = 1000;
    localparam int WHI   = 2000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        halt = 1'b0;
    logic [1:0]  cmd_ch = '0;
    logic [15:0] cmd_width_us = '0;
    logic        cmd_ready;
    logic [16*NCH-1:0] width_us;
    logic [NCH-1:0]    busy;
    logic        frame_tick;
    logic        all_idle;

    always #5 clk = ~clk;

    servo_motion_ctrl #(
        .CLK_HZ   (1_000_000),
        .NUM_CH   (NCH),
        .FRAME_US (100)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_ch       (cmd_ch),
        .cmd_width_us (cmd_width_us),
        .halt         (halt),
        .width_us     (width_us),
        .busy         (busy),
        .frame_tick   (frame_tick),
        .all_idle     (all_idle)
    );

    typedef struct {
        int w [NCH];
        int busy;
        bit tick;
        bit last;
    } exp_t;

    exp_t q [$];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Reference model: frame-level positions, one snapshot per clock edge.
    int m_cur [NCH];
    int m_tgt [NCH];
    int mcnt = 0;

    initial begin
        exp_t e;
        bit   upd, rdy;
        int   w;
        forever begin
            @(posedge clk);
            if (rst) begin
                mcnt = 0;
                for (int i = 0; i < NCH; i++) begin
                    m_cur[i] = HOME;
                    m_tgt[i] = HOME;
                end
            end else begin
                upd = (mcnt == FT - 1);
                rdy = !halt && !upd;
                if (halt) begin
                    for (int i = 0; i < NCH; i++) m_tgt[i] = m_cur[i];
                end else if (upd) begin
                    for (int i = 0; i < NCH; i++) begin
                        if (m_tgt[i] > m_cur[i])
                            m_cur[i] += (m_tgt[i] - m_cur[i] < STEP) ? m_tgt[i] - m_cur[i] : STEP;
                        else if (m_tgt[i] < m_cur[i])
                            m_cur[i] -= (m_cur[i] - m_tgt[i] < STEP) ? m_cur[i] - m_tgt[i] : STEP;
                    end
                end else if (cmd_valid && rdy) begin
                    w = int'(cmd_width_us);
                    if (w < WLO) w = WLO;
                    if (w > WHI) w = WHI;
                    m_tgt[int'(cmd_ch)] = w;
                end
                mcnt = (mcnt + 1) % FT;
            end
            e.busy = 0;
            for (int i = 0; i < NCH; i++) begin
                e.w[i] = m_cur[i];
                if (m_cur[i] != m_tgt[i]) e.busy |= (1 << i);
            end
            e.tick = !rst && (mcnt == FT - 1);
            e.last = e.tick;
            q.push_back(e);
        end
    end

    // Monitor: compares registered outputs and the live cmd_ready.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() == 0) begin
                timeout("scoreboard_empty");
            end else begin
                e = q.pop_front();
                for (int i = 0; i < NCH; i++)
                    chk($sformatf("width_ch%0d", i), int'(width_us[16*i +: 16]), e.w[i]);
                chk("busy", int'(busy), e.busy);
                chk("all_idle", int'(all_idle), int'(e.busy == 0));
                chk("frame_tick", int'(frame_tick), int'(e.tick));
                chk("cmd_ready", int'(cmd_ready), int'(!rst && !halt && !e.last));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns one step after the update edge, i.e. with the counter at 0.
    task automatic wait_tick();
        int k = 0;
        forever begin
            @(negedge clk);
            if (frame_tick) break;
            if (++k > 3 * FT) begin
                timeout("wait_tick");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        repeat (n) wait_tick();
    endtask

    task automatic send(input int ch, input int w);
        int k = 0;
        cmd_valid    = 1'b1;
        cmd_ch       = ch[1:0];
        cmd_width_us = w[15:0];
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            if (++k > 5 * FT) begin
                timeout("cmd_accept");
                break;
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    initial begin
        // reset and free-running frame timing
        cyc(3);
        rst = 1'b0;
        cyc(250);

        // simple move on ch1
        send(1, 1600);
        frames(12);

        // clamp high, then clamp low
        send(0, 2500);
        frames(52);
        send(0, 0);
        frames(102);

        // retarget mid-move, then an odd-sized final step
        send(2, 1600);
        frames(3);
        send(2, 1500);
        frames(4);
        send(3, 1505);
        frames(2);

        // halt at 1540 across a frame tick with a command waiting behind it
        send(0, 1500);
        frames(51);
        send(0, 1600);
        frames(4);
        cyc(98);
        halt = 1'b1;
        fork
            begin cyc(3); halt = 1'b0; end
            send(1, 1700);
        join
        frames(12);

        // command offered on the frame_tick cycle
        wait_tick();
        cyc(FT - 1);
        send(2, 1800);
        frames(2);

        // reset mid-move
        send(0, 1600);
        frames(3);
        cyc(10);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(250);

        // randomized commands, halts and resets
        repeat (300) begin
            int r;
            r = $urandom_range(0, 19);
            if (r == 0) begin
                rst = 1'b1;
                cyc($urandom_range(1, 2));
                rst = 1'b0;
            end else if (r == 1) begin
                halt = 1'b1;
                cyc($urandom_range(1, 4));
                halt = 1'b0;
            end else begin
                send($urandom_range(0, NCH - 1), $urandom_range(800, 2300));
            end
            cyc($urandom_range(0, 120));
        end

        cyc(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
